// File: rtl/dec_ascii_formatter_if.sv
//==============================================================================
// Module      : dec_ascii_formatter_if
// Description : Sink (binary value in) and source (ASCII byte out) signal
//               bundle for dec_ascii_formatter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dec_ascii_formatter_if #(
   parameter int WIDTH = 16
);
   logic             SINK_VALID;
   logic [WIDTH-1:0] SINK_DATA;
   logic             SINK_READY;
   logic             SOURCE_VALID;
   logic [7:0]       SOURCE_DATA;

   // Producer of binary values / consumer of ASCII bytes
   modport master (
      output SINK_VALID,
      output SINK_DATA,
      input  SINK_READY,
      input  SOURCE_VALID,
      input  SOURCE_DATA
   );

   // The formatter itself
   modport slave (
      input  SINK_VALID,
      input  SINK_DATA,
      output SINK_READY,
      output SOURCE_VALID,
      output SOURCE_DATA
   );
endinterface

`default_nettype wire

// File: rtl/dec_ascii_formatter.sv
//==============================================================================
// Module      : dec_ascii_formatter
// Description : Converts an unsigned WIDTH-bit value to decimal ASCII digits
//               (leading zeros suppressed) using serial double-dabble, one
//               bit per cycle, then streams the digits MSD first.
//               Optional macro DEC_ASCII_FORMATTER_LF_EN appends a 0x0A
//               terminator byte after every number.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dec_ascii_formatter #(
   parameter int WIDTH = 16
) (
   input  wire logic                 CLK,
   input  wire logic                 RESET_n,
   dec_ascii_formatter_if.slave      bus
);

   localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

`ifdef DEC_ASCII_FORMATTER_LF_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2,
      TERM = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;
`endif

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] value;       // captured value, shifted out MSB first
   logic [19:0]      bcd;         // five BCD digits
   logic [19:0]      bcd_adj;     // bcd after the add-3 correction
   logic [4:0]       bit_cnt;
   logic [2:0]       ptr;         // digit currently being emitted
   logic             ptr_loaded;  // ptr holds the most significant nonzero digit
   logic [2:0]       msd;         // index of most significant nonzero digit
   logic [3:0]       cur_digit;

   logic             ready;
   logic             src_valid;
   logic [7:0]       src_data;

   assign bus.SINK_READY   = ready;
   assign bus.SOURCE_VALID = src_valid;
   assign bus.SOURCE_DATA  = src_data;

   // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   // Locate the most significant nonzero digit; zero collapses to digit 0
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < 5; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) begin
            msd = 3'(i);
         end
      end
   end

   // Select the BCD digit addressed by ptr
   always_comb begin
      case (ptr)
         3'd0:    cur_digit = bcd[3:0];
         3'd1:    cur_digit = bcd[7:4];
         3'd2:    cur_digit = bcd[11:8];
         3'd3:    cur_digit = bcd[15:12];
         3'd4:    cur_digit = bcd[19:16];
         default: cur_digit = 4'd0;
      endcase
   end

   // State register; asynchronous reset aborts any conversion in flight
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode; outputs are Moore so reset silences them at once
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      src_valid = 1'b0;
      src_data  = 8'h00;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.SINK_VALID) begin
               state_nxt = CONV;
            end
         end
         CONV: begin
            if (bit_cnt == LAST_BIT) begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            // The first EMIT cycle only loads ptr; digits flow after that
            if (ptr_loaded) begin
               src_valid = 1'b1;
               src_data  = {4'h3, cur_digit};
               if (ptr == 3'd0) begin
`ifdef DEC_ASCII_FORMATTER_LF_EN
                  state_nxt = TERM;
`else
                  state_nxt = IDLE;
`endif
               end
            end
         end
`ifdef DEC_ASCII_FORMATTER_LF_EN
         TERM: begin
            src_valid = 1'b1;
            src_data  = 8'h0A;
            state_nxt = IDLE;
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture, serial double-dabble, and digit pointer walk
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         value      <= '0;
         bcd        <= '0;
         bit_cnt    <= '0;
         ptr        <= '0;
         ptr_loaded <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.SINK_VALID) begin
                  value   <= bus.SINK_DATA;
                  bcd     <= '0;
                  bit_cnt <= '0;
               end
            end
            CONV: begin
               value   <= value << 1;
               bcd     <= (bcd_adj << 1) | {19'd0, value[WIDTH-1]};
               bit_cnt <= bit_cnt + 5'd1;
            end
            EMIT: begin
               if (!ptr_loaded) begin
                  ptr        <= msd;
                  ptr_loaded <= 1'b1;
               end else if (ptr == 3'd0) begin
                  ptr_loaded <= 1'b0;
               end else begin
                  ptr <= ptr - 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire
